// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - instruction sequencer for one weight-stationary tile pass
// Outputs are decoded from the next state so inst/busy/done change on the same edge as the state register.
module core_seq_ctrl #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_bw = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [addr_bw-1:0] w_base,
   input  logic [addr_bw-1:0] x_base,
   input  logic [addr_bw-1:0] p_base,
   input  logic [addr_bw-1:0] len,
   input  logic               ofifo_valid,
   output logic [33:0]        inst,
   output logic               busy,
   output logic               done
);
   localparam int CW = addr_bw + 1;
   localparam logic [CW-1:0] ROW_C    = CW'(row);
   localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
   localparam logic [33:0]   IDLE_WORD = 34'h1_800C_0000;

   typedef enum logic [2:0] {IDLE, W_L0, KLOAD, BUBBLE, X_L0, EXEC, DRAIN, DONE} state_t;

   state_t             state, stateNext;
   logic [CW-1:0]      cnt, cntNext, lenExt;
   logic [addr_bw-1:0] wBase, xBase, pBase, lenR;
   logic [addr_bw-1:0] wSel, wrAddr;
   logic               wrNext, busyNext, doneNext;
   logic [33:0]        instNext;

   assign lenExt = {1'b0, lenR};
   // W_L0 is entered straight from IDLE, before wBase has been latched
   assign wSel   = (state == IDLE) ? w_base : wBase;

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      wrNext    = 1'b0;
      wrAddr    = pBase;
      instNext  = IDLE_WORD;
      case (state)
         IDLE: if (start) begin
            cntNext   = '0;
            stateNext = (len == '0) ? DONE : W_L0;
         end
         W_L0: if (cnt == ROW_C) begin
            stateNext = KLOAD;
            cntNext   = '0;
         end else cntNext = cnt + 1'b1;
         KLOAD: if (cnt == COL_LAST) begin
            stateNext = BUBBLE;
            cntNext   = '0;
         end else cntNext = cnt + 1'b1;
         BUBBLE: begin
            stateNext = X_L0;
            cntNext   = '0;
         end
         X_L0: if (cnt == lenExt) begin
            stateNext = EXEC;
            cntNext   = '0;
         end else cntNext = cnt + 1'b1;
         EXEC: if (cnt == lenExt - 1'b1) begin
            // cnt becomes the drain write index j; the first write may issue on entry
            stateNext = DRAIN;
            wrNext    = ofifo_valid;
            wrAddr    = pBase;
            cntNext   = CW'(ofifo_valid);
         end else cntNext = cnt + 1'b1;
         DRAIN: if (cnt == lenExt) begin
            stateNext = DONE;
            cntNext   = '0;
         end else if (ofifo_valid) begin
            wrNext  = 1'b1;
            wrAddr  = pBase + cnt[addr_bw-1:0];
            cntNext = cnt + 1'b1;
         end
         DONE: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase

      case (stateNext)
         W_L0: begin
            if (cntNext < ROW_C) begin
               instNext[19]   = 1'b0;
               instNext[17:7] = wSel + cntNext[addr_bw-1:0];
            end
            if (cntNext != '0) instNext[2] = 1'b1;
         end
         KLOAD: begin
            instNext[3] = 1'b1;
            instNext[0] = 1'b1;
         end
         X_L0: begin
            if (cntNext < lenExt) begin
               instNext[19]   = 1'b0;
               instNext[17:7] = xBase + cntNext[addr_bw-1:0];
            end
            if (cntNext != '0) instNext[2] = 1'b1;
         end
         EXEC: begin
            instNext[3] = 1'b1;
            instNext[1] = 1'b1;
         end
         DRAIN: if (wrNext) begin
            instNext[6]     = 1'b1;
            instNext[32]    = 1'b0;
            instNext[31]    = 1'b0;
            instNext[30:20] = wrAddr;
         end
         default: ;
      endcase

      busyNext = (stateNext != IDLE) && (stateNext != DONE);
      doneNext = (stateNext == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         wBase <= '0;
         xBase <= '0;
         pBase <= '0;
         lenR  <= '0;
         inst  <= IDLE_WORD;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         inst  <= instNext;
         busy  <= busyNext;
         done  <= doneNext;
         if (state == IDLE && start) begin
            wBase <= w_base;
            xBase <= x_base;
            pBase <= p_base;
            lenR  <= len;
         end
      end
   end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - directed vector bench for core_seq_ctrl
module tb_core_seq_ctrl;
   localparam longint IDLE_W = 64'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [10:0] w_base = '0, x_base = '0, p_base = '0, len = '0;
   logic        ofifo_valid = 1'b0;
   logic [33:0] inst;
   logic        busy, done;

   int nChecks = 0;
   int nErr = 0;

   core_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
      .p_base(p_base), .len(len), .ofifo_valid(ofifo_valid), .inst(inst),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int w; int x; int p; int l; int mode; int lat; int loads;
   } vec_t;
   vec_t vecs[6];

   logic [33:0] tInst[0:199];
   logic        tBusy[0:199];

   task automatic check(input string name, input longint act, input longint exp);
      nChecks++;
      if (act != exp) begin
         nErr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic startPass(input int w, input int x, input int p, input int l);
      @(negedge clk);
      w_base = 11'(w); x_base = 11'(x); p_base = 11'(p); len = 11'(l);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic runVec(input vec_t v);
      int doneAt, extra, nRd, rdBad, nWr, wrBad, nLoad, nExec, nL0wr, lagBad, bitBad, lastLoad, busyBad;
      int expRd[$];
      int wCyc[$];
      int expW[3];
      logic [4:0] pat;
      pat = 5'b10101;
      expW = '{26, 28, 30};
      check("idle_inst", longint'(inst), IDLE_W);
      check("idle_busy", busy, 0);
      startPass(v.w, v.x, v.p, v.l);
      doneAt = -1;
      for (int t = 1; t < 200; t++) begin
         if (t > 1) @(negedge clk);
         tInst[t] = inst;
         tBusy[t] = busy;
         if (v.mode == 1) ofifo_valid = (t >= 25 && t <= 29) ? pat[t-25] : 1'b0;
         else ofifo_valid = 1'b1;
         if (v.mode == 2 && t == 12) begin
            start = 1'b1; w_base = 11'd500; x_base = 11'd600; p_base = 11'd700; len = 11'd2;
         end
         if (v.mode == 2 && t == 13) start = 1'b0;
         if (done) begin
            doneAt = t;
            break;
         end
      end
      check("done_latency", doneAt, v.lat);
      // start during the DONE cycle must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      for (int t = 0; t < 30; t++) begin
         if (busy || done) extra++;
         @(negedge clk);
      end
      check("after_done_quiet", extra, 0);

      if (v.l > 0) begin
         for (int k = 0; k < 8; k++) expRd.push_back((v.w + k) % 2048);
         for (int k = 0; k < v.l; k++) expRd.push_back((v.x + k) % 2048);
      end
      nRd = 0; rdBad = 0; nWr = 0; wrBad = 0; nLoad = 0; nExec = 0; nL0wr = 0;
      lagBad = 0; bitBad = 0; lastLoad = -1; busyBad = 0;
      for (int t = 1; t <= ((doneAt > 0) ? doneAt : 199); t++) begin
         if (!tInst[t][19]) begin
            if (nRd >= expRd.size() || int'(tInst[t][17:7]) != expRd[nRd]) rdBad++;
            nRd++;
         end
         if (!tInst[t][32]) begin
            if (int'(tInst[t][30:20]) != (v.p + nWr) % 2048) wrBad++;
            nWr++;
            wCyc.push_back(t);
         end
         if (tInst[t][0]) begin nLoad++; lastLoad = t; end
         if (tInst[t][1]) nExec++;
         if (tInst[t][2]) nL0wr++;
         if (tInst[t][2] != ((t > 1) && !tInst[t-1][19])) lagBad++;
         if (tInst[t][33] || tInst[t][5] || tInst[t][4] || !tInst[t][18]) bitBad++;
         if (tInst[t][6] != !tInst[t][32] || tInst[t][31] != tInst[t][32]) bitBad++;
         if (tBusy[t] != (t != doneAt)) busyBad++;
      end
      check("read_count", nRd, expRd.size());
      check("read_addr", rdBad, 0);
      check("write_count", nWr, v.l);
      check("write_addr", wrBad, 0);
      check("load_cycles", nLoad, v.loads);
      check("exec_cycles", nExec, v.l);
      check("l0wr_cycles", nL0wr, (v.l > 0) ? 8 + v.l : 0);
      check("l0wr_lag", lagBad, 0);
      check("fixed_bits", bitBad, 0);
      check("busy_profile", busyBad, 0);
      if (lastLoad > 0) check("bubble_word", longint'(tInst[lastLoad+1]), IDLE_W);
      if (v.mode == 1) begin
         check("throttle_wr_n", wCyc.size(), 3);
         for (int i = 0; i < 3 && i < wCyc.size(); i++) check("throttle_wr_cycle", wCyc[i], expW[i]);
      end
      ofifo_valid = 1'b0;
   endtask

   initial begin
      int gotExec;
      vecs[0] = '{w: 0,    x: 8,    p: 0,    l: 4, mode: 0, lat: 32, loads: 8};
      vecs[1] = '{w: 100,  x: 200,  p: 300,  l: 3, mode: 1, lat: 31, loads: 8};
      vecs[2] = '{w: 5,    x: 9,    p: 7,    l: 0, mode: 0, lat: 1,  loads: 0};
      vecs[3] = '{w: 0,    x: 2046, p: 2045, l: 4, mode: 0, lat: 32, loads: 8};
      vecs[4] = '{w: 2044, x: 10,   p: 20,   l: 1, mode: 0, lat: 23, loads: 8};
      vecs[5] = '{w: 0,    x: 8,    p: 0,    l: 4, mode: 2, lat: 32, loads: 8};

      reset = 1'b1;
      #12;
      check("reset_inst", longint'(inst), IDLE_W);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      @(negedge clk);
      reset = 1'b0;

      startPass(0, 8, 0, 4);
      ofifo_valid = 1'b1;
      gotExec = 0;
      for (int t = 0; t < 40; t++) begin
         if (inst[1]) begin gotExec = 1; break; end
         @(negedge clk);
      end
      check("reached_exec", gotExec, 1);
      #2 reset = 1'b1;
      #1;
      check("midreset_inst", longint'(inst), IDLE_W);
      check("midreset_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      ofifo_valid = 1'b0;

      foreach (vecs[i]) runVec(vecs[i]);

      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end
endmodule
